gemm_issue_ctrl: RTL
====================

// Module: gemm_issue_ctrl
// PURPOSE
//  Issue/sequencing stage directly downstream of the GEMM functional-unit status entry.
//  Holds one dispatched GEMM op; waits for its three source matrix regs to clear via
//  writeback broadcasts; issues it to the GEMM unit; waits for completion; requests
//  writeback. Squashes speculative ops on flush.
// PARAMETERS
//  NREG  16  number of matrix registers; RW = $clog2(NREG) bits per register index
// PORTS
//  CLK        in   1   clock
//  RST        in   1   synchronous reset, active-high
//  en         in   1   dispatch valid; accepted only when disp_ready=1
//  disp_ready out  1   1 iff state==IDLE
//  md         in   RW  destination matrix reg
//  ms1/ms2/ms3 in  RW  source matrix regs
//  w1/w2/w3   in   1   source i has an outstanding producer at dispatch time
//  spec       in   1   op is issued under an unresolved branch
//  spec_clr   in   1   branch resolved correct: clear held spec bit
//  flush      in   1   mispredict: squash held op if its spec bit is set
//  wb_valid   in   1   writeback broadcast valid
//  wb_reg     in   RW  register written by the broadcast
//  gemm_valid out  1   issue request to GEMM unit
//  gemm_ready in   1   GEMM unit accepts the request
//  gemm_md/gemm_ms1/gemm_ms2/gemm_ms3 out RW  held operand fields (valid with gemm_valid)
//  gemm_done  in   1   single-cycle pulse: GEMM unit finished the accepted op
//  wbreq_valid out 1   writeback request for md
//  wbreq_md   out  RW  destination reg for the writeback
//  wbreq_ack  in   1   writeback arbiter grant
//  busy       out  1   1 in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except disp_ready=1; all held fields and wait bits 0.
//  States: IDLE, WAIT, ISSUE, EXEC, WBREQ, DRAIN.
//  Clearing spec: spec_clr clears the held spec bit in any state. If spec_clr and flush
//   are asserted in the same cycle, flush wins and uses the pre-clear spec value.
//  IDLE: on en, latch md/ms*/spec. Latch wait_i = w_i & ~(wb_valid & wb_reg==ms_i)
//   (same-cycle broadcast bypass). Then:
//   - next state is ISSUE if all latched wait bits are 0;
//   - otherwise next state is WAIT.
//  WAIT: wait_i clears when wb_valid & wb_reg==ms_i. Go to ISSUE in the cycle after
//   the last wait bit clears (registered wait bits; no combinational issue).
//  ISSUE: gemm_valid=1 and gemm_* fields stay stable until gemm_ready. On the
//   gemm_valid & gemm_ready cycle, go to EXEC. gemm_valid deasserts the next cycle.
//  EXEC: on gemm_done, go to WBREQ.
//  WBREQ: wbreq_valid=1, wbreq_md=md. Hold until wbreq_ack, then go to IDLE.
//  Flush with held spec=1:
//   - WAIT or ISSUE: go to IDLE next cycle. gemm_valid drops immediately; if
//     gemm_ready is asserted in the flush cycle, the handshake does not complete.
//   - EXEC: go to DRAIN. DRAIN waits for gemm_done, discards it, and returns to
//     IDLE with no writeback.
//   - WBREQ: unaffected (the result is already architectural).
//  Flush with spec=0: ignored in all states. en while busy: ignored.
//  A gemm_done arriving in the same cycle as flush in EXEC goes straight to IDLE.
//  Minimum latency, dispatch to gemm_valid, with no waits: 1 cycle.
// TESTING
//  Reset: assert RST mid-EXEC -> next cycle busy=0, gemm_valid=0, wbreq_valid=0,
//   disp_ready=1.
//  No-wait op: en, md=3, ms=1/2/4, w=000, gemm_ready=1 -> gemm_valid one cycle after
//   en; gemm_done -> wbreq_valid with wbreq_md=3; ack -> IDLE.
//  Waits: w=101 with ms1=5, ms3=7. Broadcast reg 7 at t+2, reg 5 at t+4 ->
//   gemm_valid rises at t+5, not earlier.
//  Bypass: en with w1=1, ms1=6, and same-cycle wb_reg=6 -> issue next cycle.
//  Backpressure: gemm_ready=0 for 4 cycles -> gemm_valid and gemm_ms* stable
//   throughout; accepted on the 5th cycle.
//  Flush: spec=1 flushed in WAIT -> IDLE, no gemm_valid. spec=1 flushed in EXEC ->
//   DRAIN; gemm_done -> IDLE with no wbreq_valid. spec_clr then flush -> op completes.

Source files
------------

// File: rtl/gemm_issue_ctrl_if.sv
// gemm_issue_ctrl_if
//   Groups the handshake and bus signals of the GEMM issue controller.
//   Dispatch : en, disp_ready, md, ms1..ms3, w1..w3, spec, spec_clr, flush
//   Wakeup   : wb_valid, wb_reg
//   Issue    : gemm_valid, gemm_ready, gemm_md, gemm_ms1..gemm_ms3, gemm_done
//   Writeback: wbreq_valid, wbreq_md, wbreq_ack
//   Status   : busy
//   slave modport is the controller side, master modport is the surrounding pipeline.
interface gemm_issue_ctrl_if #(
  parameter int RW = 4
);
  logic          en;
  logic          disp_ready;
  logic [RW-1:0] md;
  logic [RW-1:0] ms1;
  logic [RW-1:0] ms2;
  logic [RW-1:0] ms3;
  logic          w1;
  logic          w2;
  logic          w3;
  logic          spec;
  logic          spec_clr;
  logic          flush;
  logic          wb_valid;
  logic [RW-1:0] wb_reg;
  logic          gemm_valid;
  logic          gemm_ready;
  logic [RW-1:0] gemm_md;
  logic [RW-1:0] gemm_ms1;
  logic [RW-1:0] gemm_ms2;
  logic [RW-1:0] gemm_ms3;
  logic          gemm_done;
  logic          wbreq_valid;
  logic [RW-1:0] wbreq_md;
  logic          wbreq_ack;
  logic          busy;

  modport master (
    output en, md, ms1, ms2, ms3, w1, w2, w3, spec, spec_clr, flush,
           wb_valid, wb_reg, gemm_ready, gemm_done, wbreq_ack,
    input  disp_ready, gemm_valid, gemm_md, gemm_ms1, gemm_ms2, gemm_ms3,
           wbreq_valid, wbreq_md, busy
  );

  modport slave (
    input  en, md, ms1, ms2, ms3, w1, w2, w3, spec, spec_clr, flush,
           wb_valid, wb_reg, gemm_ready, gemm_done, wbreq_ack,
    output disp_ready, gemm_valid, gemm_md, gemm_ms1, gemm_ms2, gemm_ms3,
           wbreq_valid, wbreq_md, busy
  );
endinterface

// File: rtl/gemm_issue_ctrl.sv
// gemm_issue_ctrl
//   Holds one dispatched GEMM op, waits for its three source matrix registers
//   to be written back, issues it to the GEMM unit, waits for completion and
//   requests writeback of the destination. Speculative ops are squashed on flush.
// Ports
//   CLK  clock
//   RST  synchronous reset, active-high
//   bus  gemm_issue_ctrl_if.slave (dispatch, wakeup, issue, writeback, status)
//
// state | meaning
// IDLE  | empty, ready for dispatch
// WAIT  | op held, at least one source still has an outstanding producer
// ISSUE | gemm_valid asserted, waiting for gemm_ready
// EXEC  | accepted by GEMM unit, waiting for gemm_done
// WBREQ | requesting writeback of md, waiting for wbreq_ack
// DRAIN | squashed while executing, discarding the coming gemm_done
module gemm_issue_ctrl #(
  parameter int NREG = 16
) (
  input  logic               CLK,
  input  logic               RST,
  gemm_issue_ctrl_if.slave   bus
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, EXEC, WBREQ, DRAIN} state_t;

  state_t        state, state_n;
  logic [RW-1:0] md_q, ms1_q, ms2_q, ms3_q;
  logic [RW-1:0] md_n, ms1_n, ms2_n, ms3_n;
  logic          spec_q, spec_n;
  logic [2:0]    wait_q, wait_n;
  logic          flush_eff;
  logic [2:0]    hit_in, hit_q;

  // Flush only acts on a held speculative op, using the spec bit before any
  // same-cycle spec_clr takes effect.
  assign flush_eff = bus.flush & spec_q;

  // Writeback matches against incoming sources (dispatch bypass) and held sources.
  assign hit_in = {bus.wb_valid && (bus.wb_reg == bus.ms3),
                   bus.wb_valid && (bus.wb_reg == bus.ms2),
                   bus.wb_valid && (bus.wb_reg == bus.ms1)};
  assign hit_q  = {bus.wb_valid && (bus.wb_reg == ms3_q),
                   bus.wb_valid && (bus.wb_reg == ms2_q),
                   bus.wb_valid && (bus.wb_reg == ms1_q)};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      md_q   <= '0;
      ms1_q  <= '0;
      ms2_q  <= '0;
      ms3_q  <= '0;
      spec_q <= 1'b0;
      wait_q <= '0;
    end else begin
      state  <= state_n;
      md_q   <= md_n;
      ms1_q  <= ms1_n;
      ms2_q  <= ms2_n;
      ms3_q  <= ms3_n;
      spec_q <= spec_n;
      wait_q <= wait_n;
    end
  end

  always_comb begin
    state_n         = state;
    md_n            = md_q;
    ms1_n           = ms1_q;
    ms2_n           = ms2_q;
    ms3_n           = ms3_q;
    spec_n          = spec_q & ~bus.spec_clr;
    wait_n          = wait_q & ~hit_q;
    bus.gemm_valid  = 1'b0;
    bus.wbreq_valid = 1'b0;

    case (state)
      IDLE: begin
        wait_n = wait_q;
        if (bus.en) begin
          md_n   = bus.md;
          ms1_n  = bus.ms1;
          ms2_n  = bus.ms2;
          ms3_n  = bus.ms3;
          spec_n = bus.spec;
          wait_n = {bus.w3, bus.w2, bus.w1} & ~hit_in;
          state_n = (wait_n == 3'b000) ? ISSUE : WAIT;
        end
      end
      // Decision uses the next-cycle wait bits, so ISSUE is entered the cycle
      // after the last broadcast without issuing combinationally.
      WAIT: begin
        if (flush_eff)
          state_n = IDLE;
        else if (wait_n == 3'b000)
          state_n = ISSUE;
      end
      ISSUE: begin
        bus.gemm_valid = ~flush_eff;
        if (flush_eff)
          state_n = IDLE;
        else if (bus.gemm_ready)
          state_n = EXEC;
      end
      EXEC: begin
        if (flush_eff)
          state_n = bus.gemm_done ? IDLE : DRAIN;
        else if (bus.gemm_done)
          state_n = WBREQ;
      end
      WBREQ: begin
        bus.wbreq_valid = 1'b1;
        if (bus.wbreq_ack)
          state_n = IDLE;
      end
      DRAIN: begin
        if (bus.gemm_done)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.disp_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.gemm_md    = md_q;
  assign bus.gemm_ms1   = ms1_q;
  assign bus.gemm_ms2   = ms2_q;
  assign bus.gemm_ms3   = ms3_q;
  assign bus.wbreq_md   = md_q;
endmodule
